sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, external SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 2, SRAM strobe length in clk cycles, legal range 1..15.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_rdata out DATA_W, cpu_ack out 1: CPU requester.
REQ-007 SHALL have ports dma_req in 1, dma_we in 1, dma_addr in ADDR_W, dma_wdata in DATA_W, dma_rdata out DATA_W, dma_ack out 1: disc-data DMA requester.
REQ-008 SHALL have ports sram_a out ADDR_W, sram_d_out out DATA_W, sram_d_in in DATA_W, sram_cs out 1, sram_oe out 1, sram_we out 1: external SRAM, all active-high.
REQ-009 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-011 IDLE: if any req is high, SHALL grant one requester, latch its addr/wdata/we into sram_a/sram_d_out/wr flag, and enter ACCESS on the same edge.
REQ-012 ACCESS: SHALL hold sram_cs=1, plus sram_oe=1 for reads or sram_we=1 for writes, for exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter.
REQ-013 On the edge ending the last ACCESS cycle of a read, SHALL capture sram_d_in into the granted requester's rdata register.
REQ-014 DONE: SHALL drive cs/oe/we low, pulse the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-015 Request-to-ack latency SHALL be ACCESS_CYCLES+1 cycles; ack SHALL appear in cycle N+ACCESS_CYCLES+1 when req is first seen in cycle N.
REQ-016 Minimum access period SHALL be ACCESS_CYCLES+2 cycles.
REQ-017 Requester protocol: hold req, we, addr and wdata stable until ack; drop req on the edge at which ack is seen. Arbiter SHALL sample req only in IDLE.
REQ-018 rdata SHALL hold its value until the next read completes for that requester; writes SHALL leave rdata unchanged.
REQ-019 sram_a and sram_d_out SHALL stay stable from the grant edge through DONE.
REQ-020 The non-granted requester SHALL see ack=0, and its rdata SHALL be unchanged.

Reset
REQ-021 rst high at any edge SHALL force IDLE and the following outputs: sram_cs/oe/we=0, sram_a=0, sram_d_out=0, cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, busy=0, count=0.
REQ-022 Reset mid-ACCESS SHALL abort the transfer with no ack issued; the abort SHALL cause no rdata update.
REQ-023 Reset SHALL set the last-grant register to DMA, so the CPU wins the first tie.

Configuration
REQ-024 Macro SRAM_ARB_RR_EN defined: simultaneous requests in IDLE SHALL go to the requester not granted last (round-robin), and last-grant SHALL update on every grant.
REQ-025 Macro undefined: CPU SHALL always win a tie (fixed priority); last-grant logic SHALL be absent. DMA starvation under continuous CPU requests is accepted.

Structure
REQ-026 Shared package sram_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), requester IDs (GNT_CPU=1'b0, GNT_DMA=1'b1) and the counter width constant.
REQ-027 Grant selection SHALL be the sub-module sram_arb_pick: combinational, with inputs cpu_req, dma_req and last_grant, and output grant id plus valid.
REQ-028 The FSM, counter and datapath registers SHALL reside in sram_arbiter.

Verification
REQ-029 ACCESS_CYCLES=2, CPU reads addr 0x00010 with sram_d_in=0xA5 -> cs/oe high for 2 cycles, cpu_ack in cycle N+3, cpu_rdata=0xA5.
REQ-030 DMA writes 0x3C to 0x7FFFF -> sram_a=0x7FFFF, sram_d_out=0x3C, sram_we high for 2 cycles, dma_ack pulse, cpu_rdata unchanged.
REQ-031 Both req high continuously, four grants -> with SRAM_ARB_RR_EN the order is CPU, DMA, CPU, DMA; without it the order is CPU, CPU, CPU, CPU.
REQ-032 rst asserted in the 2nd ACCESS cycle of a CPU read -> next cycle IDLE, all strobes 0, no cpu_ack, cpu_rdata=0.
REQ-033 ACCESS_CYCLES=1, back-to-back CPU writes -> acks spaced exactly 3 cycles apart, busy low for one cycle between accesses.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, requester IDs and
// the access-counter width.
package sram_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

  function automatic gnt_t other_id(input gnt_t id);
    return (id == GNT_CPU) ? GNT_DMA : GNT_CPU;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection: a lone requester wins outright, a tie goes
// to the requester that was not granted last.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  gnt_t last_grant,
  output gnt_t grant,
  output logic valid
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    valid = cpu_req | dma_req;
    grant = GNT_CPU;
    if (cpu_req && dma_req) begin
      grant = other_id(last_grant);
    end else if (dma_req) begin
      grant = GNT_DMA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU / DMA) arbiter for an asynchronous external SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default is CPU priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,

  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d_out,
  input  logic [DATA_W-1:0] sram_d_in,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,

  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              wr;
  gnt_t              gnt;
  gnt_t              last_grant;
  gnt_t              pick_grant;
  logic              pick_valid;

  logic grant_now;
  logic read_done;

  assign grant_now = (state == IDLE) && pick_valid;
  assign read_done = (state == ACCESS) && (count == CNT_LAST) && !wr;

  sram_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_DMA;
    end else if (grant_now) begin
      last_grant <= pick_grant;
    end
  end
`else
  // Tying last_grant to DMA makes every tie resolve to the CPU.
  assign last_grant = GNT_DMA;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      wr         <= 1'b0;
      gnt        <= GNT_CPU;
      sram_a     <= '0;
      sram_d_out <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;

      if (grant_now) begin
        gnt <= pick_grant;
        if (pick_grant == GNT_DMA) begin
          sram_a     <= dma_addr;
          sram_d_out <= dma_wdata;
          wr         <= dma_we;
        end else begin
          sram_a     <= cpu_addr;
          sram_d_out <= cpu_wdata;
          wr         <= cpu_we;
        end
      end

      // Read data is taken on the edge that closes the strobe window.
      if (read_done) begin
        if (gnt == GNT_DMA) begin
          dma_rdata <= sram_d_in;
        end else begin
          cpu_rdata <= sram_d_in;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_we   = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = ACCESS;
          count_nxt = CNT_INIT;
        end
      end
      ACCESS: begin
        sram_cs   = 1'b1;
        sram_oe   = !wr;
        sram_we   = wr;
        count_nxt = count - CNT_LAST;
        if (count == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_ack   = (gnt == GNT_CPU);
        dma_ack   = (gnt == GNT_DMA);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level timing model with a
// behavioural SRAM, plus directed reset-abort and single-cycle-strobe cases.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int AC = 2;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Main instance (ACCESS_CYCLES = 2)
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d_out, sram_d_in;
  logic          sram_cs, sram_oe, sram_we, busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_ack    (dma_ack),
    .sram_a     (sram_a),
    .sram_d_out (sram_d_out),
    .sram_d_in  (sram_d_in),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .busy       (busy)
  );

  // Second instance with a single-cycle strobe (ACCESS_CYCLES = 1)
  logic          b_cpu_req, b_cpu_we, b_cpu_ack;
  logic [AW-1:0] b_cpu_addr;
  logic [DW-1:0] b_cpu_wdata, b_cpu_rdata;
  logic          b_dma_req, b_dma_we, b_dma_ack;
  logic [AW-1:0] b_dma_addr;
  logic [DW-1:0] b_dma_wdata, b_dma_rdata;
  logic [AW-1:0] b_sram_a;
  logic [DW-1:0] b_sram_d_out, b_sram_d_in;
  logic          b_sram_cs, b_sram_oe, b_sram_we, b_busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut_ac1 (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (b_cpu_req),
    .cpu_we     (b_cpu_we),
    .cpu_addr   (b_cpu_addr),
    .cpu_wdata  (b_cpu_wdata),
    .cpu_rdata  (b_cpu_rdata),
    .cpu_ack    (b_cpu_ack),
    .dma_req    (b_dma_req),
    .dma_we     (b_dma_we),
    .dma_addr   (b_dma_addr),
    .dma_wdata  (b_dma_wdata),
    .dma_rdata  (b_dma_rdata),
    .dma_ack    (b_dma_ack),
    .sram_a     (b_sram_a),
    .sram_d_out (b_sram_d_out),
    .sram_d_in  (b_sram_d_in),
    .sram_cs    (b_sram_cs),
    .sram_oe    (b_sram_oe),
    .sram_we    (b_sram_we),
    .busy       (b_busy)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Requester-side stimulus state (index 0 = CPU, 1 = DMA)
  txn_t q_cpu [$];
  txn_t q_dma [$];
  txn_t cur [2];
  bit   active [2];
  int   gap [2];
  int   max_gap;

  // Reference model: in-flight grant, arbiter availability, expected data
  int            g_who, g_t, free_at, last;
  txn_t          g_tx;
  logic [DW-1:0] mmem [int];
  logic [DW-1:0] dev [int];
  logic [DW-1:0] m_rdata [2];
  int            dut_order [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
  endfunction

  // One clock cycle, called just after a falling edge.
  task automatic step();
    bit in_acc, in_done;
    int w;
    cyc++;
    if (sram_cs && sram_we) dev[int'(sram_a)] = sram_d_out;
    if (cpu_ack) dut_order.push_back(0);
    if (dma_ack) dut_order.push_back(1);

    in_acc  = (g_who >= 0) && (cyc > g_t) && (cyc <= g_t + AC);
    in_done = (g_who >= 0) && (cyc == g_t + AC + 1);
    check("sram_cs", 32'(sram_cs), 32'(in_acc));
    check("sram_oe", 32'(sram_oe), 32'(in_acc && !g_tx.we));
    check("sram_we", 32'(sram_we), 32'(in_acc && g_tx.we));
    check("busy",    32'(busy),    32'(in_acc || in_done));
    check("cpu_ack", 32'(cpu_ack), 32'(in_done && g_who == 0));
    check("dma_ack", 32'(dma_ack), 32'(in_done && g_who == 1));
    if (in_acc || in_done) begin
      check("sram_a", 32'(sram_a), 32'(g_tx.addr));
      if (g_tx.we) check("sram_d_out", 32'(sram_d_out), 32'(g_tx.wdata));
    end
    if (in_done) begin
      if (g_tx.we) mmem[int'(g_tx.addr)] = g_tx.wdata;
      else m_rdata[g_who] = exp_mem(g_tx.addr);
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata[0]));
      check("dma_rdata", 32'(dma_rdata), 32'(m_rdata[1]));
      active[g_who] = 1'b0;
      gap[g_who]    = $urandom_range(0, max_gap);
      g_who         = -1;
    end

    for (int r = 0; r < 2; r++) begin
      if (!active[r]) begin
        if (gap[r] > 0) gap[r]--;
        else if (r == 0 && q_cpu.size() > 0) begin cur[0] = q_cpu.pop_front(); active[0] = 1'b1; end
        else if (r == 1 && q_dma.size() > 0) begin cur[1] = q_dma.pop_front(); active[1] = 1'b1; end
      end
    end
    cpu_req = active[0]; cpu_we = cur[0].we; cpu_addr = cur[0].addr; cpu_wdata = cur[0].wdata;
    dma_req = active[1]; dma_we = cur[1].we; dma_addr = cur[1].addr; dma_wdata = cur[1].wdata;

    // Grant decided on the edge closing this cycle
    if (g_who < 0 && cyc >= free_at && (active[0] || active[1])) begin
      if (active[0] && active[1]) w = RR ? 1 - last : 0;
      else w = active[0] ? 0 : 1;
      g_who   = w;
      g_t     = cyc;
      g_tx    = cur[w];
      free_at = cyc + AC + 2;
      last    = w;
    end

    sram_d_in = dev.exists(int'(sram_a)) ? dev[int'(sram_a)] : init_val(sram_a);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      step();
      n++;
    end while ((q_cpu.size() != 0 || q_dma.size() != 0 || active[0] || active[1] || g_who >= 0)
               && n < max_cyc);
    check("drain_in_budget", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   r, k, acks, last_ack, low_cnt, we_cyc;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    sram_d_in = '0;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = '0; b_dma_wdata = '0;
    b_sram_d_in = '0;
    cur[0] = '0; cur[1] = '0;
    active[0] = 1'b0; active[1] = 1'b0;
    gap[0] = 0; gap[1] = 0;
    max_gap = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_cs",        32'(sram_cs),    32'd0);
    check("rst_oe",        32'(sram_oe),    32'd0);
    check("rst_we",        32'(sram_we),    32'd0);
    check("rst_a",         32'(sram_a),     32'd0);
    check("rst_d_out",     32'(sram_d_out), 32'd0);
    check("rst_acks",      32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata),  32'd0);
    check("rst_dma_rdata", 32'(dma_rdata),  32'd0);
    check("rst_ac1_busy",  32'(b_busy),     32'd0);
    rst = 1'b0;
    g_who = -1; free_at = 0; last = 1;
    m_rdata[0] = '0; m_rdata[1] = '0;

    // Simultaneous CPU read of 0x00010 and DMA write of 0x3C to 0x7FFFF
    dev[16] = 8'hA5;
    mmem[16] = 8'hA5;
    t.we = 1'b0; t.addr = AW'(16); t.wdata = '0;          q_cpu.push_back(t);
    t.we = 1'b1; t.addr = AW'('h7FFFF); t.wdata = 8'h3C;  q_dma.push_back(t);
    run_until_idle(50);
    check("cpu_read_a5",   32'(cpu_rdata), 32'hA5);
    check("dma_write_3c",  32'(dev.exists('h7FFFF) ? dev['h7FFFF] : 8'h00), 32'h3C);

    // Continuous requests from both sides: grant order
    dut_order.delete();
    for (int i = 0; i < 4; i++) begin
      t.we = 1'b0; t.addr = AW'(i);      t.wdata = '0; q_cpu.push_back(t);
      t.we = 1'b0; t.addr = AW'(i + 64); t.wdata = '0; q_dma.push_back(t);
    end
    run_until_idle(200);
    check("tie_ack_count", 32'(dut_order.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < dut_order.size(); i++)
      check("tie_order", 32'(dut_order[i]), RR ? 32'(i % 2) : 32'd0);

    // Randomised mixed traffic with idle gaps
    max_gap = 2;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 1);
      t.we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       t.addr = '0;
        1:       t.addr = '1;
        default: t.addr = AW'($urandom_range(0, 31));
      endcase
      t.wdata = DW'($urandom);
      if (r == 0) q_cpu.push_back(t);
      else q_dma.push_back(t);
    end
    run_until_idle(2000);

    // Reset during the second ACCESS cycle of a CPU read
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(16); dma_req = 1'b0;
    sram_d_in = 8'hA5;
    @(negedge clk);
    check("abort_acc1_cs", 32'(sram_cs), 32'd1);
    @(negedge clk);
    check("abort_acc2_oe", 32'(sram_oe), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      32'(busy), 32'd0);
    check("abort_strobes",   32'({sram_cs, sram_oe, sram_we}), 32'd0);
    check("abort_cpu_ack",   32'(cpu_ack), 32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("abort_sram_a",    32'(sram_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
    end

    // Single-cycle strobe: back-to-back CPU writes
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = AW'(1); b_cpu_wdata = 8'h11;
    k = 0; acks = 0; last_ack = 0; low_cnt = 0; we_cyc = 0;
    while (acks < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (b_sram_we) we_cyc++;
      if (!b_busy) low_cnt++;
      if (b_cpu_ack) begin
        if (acks == 0) check("ac1_first_ack", 32'(k), 32'd2);
        else begin
          check("ac1_ack_spacing", 32'(k - last_ack), 32'd3);
          check("ac1_busy_gap",    32'(low_cnt), 32'd1);
        end
        low_cnt  = 0;
        last_ack = k;
        acks++;
        b_cpu_addr  = b_cpu_addr + AW'(1);
        b_cpu_wdata = b_cpu_wdata + DW'(8'h11);
        if (acks == 4) b_cpu_req = 1'b0;
      end
    end
    check("ac1_acks", 32'(acks), 32'd4);
    repeat (3) @(negedge clk);
    check("ac1_we_cycles", 32'(we_cyc), 32'd4);
    check("ac1_idle", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
